// File: rtl/bsdot_seq_if.sv
// bsdot_seq_if: activation bit-plane valid/ready stream between plane buffer and feeder
interface bsdot_seq_if #(
    parameter int N = 64
);
    logic         d_valid;
    logic         d_ready;
    logic [N-1:0] D;

    modport master (output d_valid, output D, input d_ready);
    modport slave  (input d_valid, input D, output d_ready);
endinterface

// File: rtl/bsdot_seq.sv
// bsdot_seq: bit-plane feeder computing ±1-weight plane contributions and shacc load/acc/sh controls (optional BSDOT_SIGNED_EN adds sgn for two's-complement activations)
module bsdot_seq #(
    parameter int N    = 64,
    parameter int a    = 8,
    parameter int PMAX = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(PMAX+1)-1:0]  prec,
    input  logic [N-1:0]               W,
`ifdef BSDOT_SIGNED_EN
    input  logic                       sgn,
`endif
    bsdot_seq_if.slave                 pl,
    output logic signed [a-1:0]        I,
    output logic                       load,
    output logic                       acc,
    output logic                       sh,
    output logic                       last,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = $clog2(PMAX+1);
    localparam logic [PW-1:0] ONE    = 1;
    localparam logic [PW-1:0] PMAX_W = PMAX[PW-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [N-1:0]        w_q;
    logic [PW-1:0]       cnt, prec_eff;
    logic                first, accept;
    logic [a-1:0]        p_and, p_all;
    logic signed [a-1:0] c, cv;
`ifdef BSDOT_SIGNED_EN
    logic                sgn_q;
`endif

    assign pl.d_ready = state == RUN;
    assign accept     = pl.d_valid && pl.d_ready;
    assign busy       = state == RUN || state == DRAIN;
    assign done       = state == DONE;
    assign prec_eff   = prec == '0 ? ONE : (prec > PMAX_W ? PMAX_W : prec);

    // plane contribution: matches minus mismatches among set activation bits
    always_comb begin
        p_and = '0;
        p_all = '0;
        for (int i = 0; i < N; i++) begin
            p_and = p_and + {{(a-1){1'b0}}, pl.D[i] & w_q[i]};
            p_all = p_all + {{(a-1){1'b0}}, pl.D[i]};
        end
        c = (p_and << 1) - p_all;
`ifdef BSDOT_SIGNED_EN
        cv = (first && sgn_q) ? -c : c;
`else
        cv = c;
`endif
    end

    // next-state: one plane per accept, then a drain edge for shacc, then a done pulse
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (accept && cnt == ONE) ? DRAIN : RUN;
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // job latch, plane counter and registered shacc controls (pulse only on accept)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q   <= '0;
            cnt   <= '0;
            first <= 1'b0;
            I     <= '0;
            load  <= 1'b0;
            acc   <= 1'b0;
            sh    <= 1'b0;
            last  <= 1'b0;
`ifdef BSDOT_SIGNED_EN
            sgn_q <= 1'b0;
`endif
        end else begin
            load <= 1'b0;
            acc  <= 1'b0;
            sh   <= 1'b0;
            last <= 1'b0;
            if (state == IDLE && start) begin
                w_q   <= W;
                cnt   <= prec_eff;
                first <= 1'b1;
`ifdef BSDOT_SIGNED_EN
                sgn_q <= sgn;
`endif
            end
            if (accept) begin
                I     <= cv;
                load  <= first;
                acc   <= !first;
                sh    <= !first;
                last  <= cnt == ONE;
                cnt   <= cnt - ONE;
                first <= 1'b0;
            end
        end
    end
endmodule
